lsu_ram_master: RTL

- Load/store initiator that drives one port of the dual-port data RAM (en/addr/we/be/wdata, rdata one cycle later) on behalf of the core's load-store unit.
- Converts byte/half/word loads and stores at arbitrary byte addresses into word-addressed RAM accesses with byte enables.
- Splits word-crossing accesses into two consecutive RAM accesses.
- Extracts, merges and sign/zero-extends read data, and returns it with a completion pulse.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_ram_master_if.sv | 33 +++
 rtl/lsu_lane_align.sv | 45 ++++
 rtl/lsu_ram_master.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store RAM master.
//
// Contents:
//   size_e     access size encoding (byte/half/word; 2'b11 is handled as a word)
//   state_e    FSM states of lsu_ram_master
//   MASK_*     right-aligned byte-enable masks for each access size
//   size_mask  maps a raw 2-bit size to its right-aligned byte mask
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SPLIT = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // The unused encoding 2'b11 falls through to a full word.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: return MASK_BYTE;
      SZ_HALF: return MASK_HALF;
      default: return MASK_WORD;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ram_master_if.sv
// One port of the dual-port data RAM as seen by the load/store master.
//
// Signals:
//   en     access enable
//   addr   word address (ADDR_WIDTH bits)
//   we     write enable
//   be     byte enables, one per byte lane
//   wdata  lane-aligned write data
//   rdata  read data, valid the cycle after en
//
// Modports: master (the LSU side), slave (the RAM side).
interface lsu_ram_master_if #(
  parameter int ADDR_WIDTH = 8
);

  logic                  en;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [31:0]           rdata;

  modport master (
    output en, addr, we, be, wdata,
    input  rdata
  );

  modport slave (
    input  en, addr, we, be, wdata,
    output rdata
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Purely combinational byte-lane alignment for the load/store master.
//
// Store side:
//   st_size, st_off, st_wdata -> be8 (byte enables across two words)
//                               d64 (write data shifted into its lanes)
// Load side:
//   ld_size, ld_off, ld_sign_ext, ld_data64 -> ld_result
//   ld_data64 is {upper word, lower word}; the addressed bytes are shifted
//   down to bit 0, truncated to the access size and sign/zero-extended.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [7:0]  be8,
  output logic [63:0] d64,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_sign_ext,
  input  logic [63:0] ld_data64,
  output logic [31:0] ld_result
);

  logic [63:0] shifted;
  logic        unused_shifted_hi;

  always_comb begin
    be8       = {4'b0000, size_mask(st_size)} << st_off;
    d64       = {32'h0000_0000, st_wdata} << {st_off, 3'b000};
    shifted   = ld_data64 >> {ld_off, 3'b000};
    ld_result = shifted[31:0];
    case (ld_size)
      SZ_BYTE: ld_result = ld_sign_ext ? {{24{shifted[7]}}, shifted[7:0]}
                                       : {24'h00_0000, shifted[7:0]};
      SZ_HALF: ld_result = ld_sign_ext ? {{16{shifted[15]}}, shifted[15:0]}
                                       : {16'h0000, shifted[15:0]};
      default: ld_result = shifted[31:0];
    endcase
  end

  // Only the low word of the shifted load data is ever returned.
  assign unused_shifted_hi = ^shifted[63:32];

endmodule

// File: rtl/lsu_ram_master.sv
// Load/store initiator driving one port of the data RAM for the core LSU.
//
// Core side:
//   req_i/ready_o   request handshake, accepted when req_i && ready_o
//   we_i            1 = store, 0 = load
//   size_i          00 byte, 01 half, 10/11 word
//   sign_ext_i      loads: sign-extend (1) or zero-extend (0)
//   addr_i          byte address; bits [ADDR_WIDTH+1:2] select the word
//   wdata_i         right-aligned store data
//   rvalid_o        one-cycle completion pulse for loads and stores
//   rdata_o         load result, valid with rvalid_o (held across stores)
// RAM side:
//   ram             lsu_ram_master_if master port (en/addr/we/be/wdata/rdata)
//
// Accesses that cross a word boundary are split into two consecutive RAM
// accesses; a split store that is interrupted by reset keeps its first word.
module lsu_ram_master
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    ready_o,
  input  logic                    we_i,
  input  logic [1:0]              size_i,
  input  logic                    sign_ext_i,
  input  logic [31:0]             addr_i,
  input  logic [31:0]             wdata_i,
  output logic                    rvalid_o,
  output logic [31:0]             rdata_o,
  lsu_ram_master_if.master        ram
);

  state_e                state_q, state_d;

  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  sign_ext_q;
  logic                  we_q;
  logic                  split_q;
  logic [3:0]            be_hi_q;
  logic [31:0]           wdata_hi_q;
  logic [ADDR_WIDTH-1:0] addr_next_q;
  logic [31:0]           lo_hold_q;

  logic [ADDR_WIDTH-1:0] word_addr;
  logic [7:0]            be8;
  logic [63:0]           d64;
  logic                  is_split;
  logic                  accept;
  logic [63:0]           load_data64;
  logic [31:0]           load_result;
  logic                  unused_addr_hi;

  assign word_addr = addr_i[ADDR_WIDTH+1:2];
  assign is_split  = |be8[7:4];
  assign ready_o   = (state_q == ST_IDLE) && !rst_i;
  assign accept    = req_i && ready_o;

  // Upper address bits alias onto the RAM and are intentionally ignored.
  assign unused_addr_hi = ^addr_i[31:ADDR_WIDTH+2];

  // A split load glues the second word above the one captured in SPLIT.
  assign load_data64 = split_q ? {ram.rdata, lo_hold_q}
                               : {32'h0000_0000, ram.rdata};

  lsu_lane_align u_lane_align (
    .st_size     (size_i),
    .st_off      (addr_i[1:0]),
    .st_wdata    (wdata_i),
    .be8         (be8),
    .d64         (d64),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_sign_ext (sign_ext_q),
    .ld_data64   (load_data64),
    .ld_result   (load_result)
  );

  // Next-state and RAM port drive. Every RAM output stays zero unless the
  // port is enabled, and reset blocks the second half of a split access.
  always_comb begin
    state_d   = state_q;
    ram.en    = 1'b0;
    ram.addr  = '0;
    ram.we    = 1'b0;
    ram.be    = 4'b0000;
    ram.wdata = 32'h0000_0000;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          ram.en    = 1'b1;
          ram.addr  = word_addr;
          ram.we    = we_i;
          ram.be    = be8[3:0];
          ram.wdata = d64[31:0];
          state_d   = is_split ? ST_SPLIT : ST_RESP;
        end
      end
      ST_SPLIT: begin
        if (!rst_i) begin
          ram.en    = 1'b1;
          ram.addr  = addr_next_q;
          ram.we    = we_q;
          ram.be    = be_hi_q;
          ram.wdata = wdata_hi_q;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register, request holding registers and the response outputs.
  // Stores complete with rvalid_o but leave rdata_o untouched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      rvalid_o    <= 1'b0;
      rdata_o     <= 32'h0000_0000;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      sign_ext_q  <= 1'b0;
      we_q        <= 1'b0;
      split_q     <= 1'b0;
      be_hi_q     <= 4'b0000;
      wdata_hi_q  <= 32'h0000_0000;
      addr_next_q <= '0;
      lo_hold_q   <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      rvalid_o <= (state_q == ST_RESP);
      if (accept) begin
        off_q       <= addr_i[1:0];
        size_q      <= size_i;
        sign_ext_q  <= sign_ext_i;
        we_q        <= we_i;
        split_q     <= is_split;
        be_hi_q     <= be8[7:4];
        wdata_hi_q  <= d64[63:32];
        addr_next_q <= word_addr + ADDR_WIDTH'(1);
      end
      if (state_q == ST_SPLIT) begin
        lo_hold_q <= ram.rdata;
      end
      if (state_q == ST_RESP && !we_q) begin
        rdata_o <= load_result;
      end
    end
  end

endmodule
